// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard/forwarding controller: scoreboard of DEPTH in-flight writers, forward selects,
// load-use stall and redirect flush. Define HAZARD_STATS_EN to build the stall/flush cycle counters.
module pipe_hazard_unit #(
    parameter int DEPTH    = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32,
    localparam int FWD_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush,
    output logic [FWD_W-1:0]  fwd_sel_a,
    output logic [FWD_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic              valid_reg [DEPTH];
    logic [REG_AW-1:0] addr_reg  [DEPTH];
    logic              load_reg  [DEPTH];

    logic [FWD_W-1:0] sel_a;
    logic [FWD_W-1:0] sel_b;
    logic             hz_a;
    logic             hz_b;
    logic             stall_raw;
    logic             enter_next;

    // Walk from the oldest entry down so the nearest matching writer overwrites older ones.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hz_a  = 1'b0;
        hz_b  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_reg[k] && id_uses_rs && (id_rs != '0) && (addr_reg[k] == id_rs)) begin
                sel_a = FWD_W'(k + 1);
                hz_a  = load_reg[k] && (k < LOAD_LAT);
            end
            if (valid_reg[k] && id_uses_rt && (id_rt != '0) && (addr_reg[k] == id_rt)) begin
                sel_b = FWD_W'(k + 1);
                hz_b  = load_reg[k] && (k < LOAD_LAT);
            end
        end
    end

    assign stall_raw  = id_valid && (hz_a || hz_b) && !ex_redirect;
    assign stall      = !reset && stall_raw;
    assign flush      = !reset && ex_redirect;
    assign fwd_sel_a  = reset ? '0 : sel_a;
    assign fwd_sel_b  = reset ? '0 : sel_b;
    assign enter_next = id_valid && id_wr_en && (id_wr_addr != '0) && !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg[0] <= 1'b0;
            addr_reg[0]  <= '0;
            load_reg[0]  <= 1'b0;
        end else begin
            valid_reg[0] <= enter_next;
            addr_reg[0]  <= id_wr_addr;
            load_reg[0]  <= id_is_load;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    addr_reg[gi]  <= '0;
                    load_reg[gi]  <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    addr_reg[gi]  <= addr_reg[gi-1];
                    load_reg[gi]  <= load_reg[gi-1];
                end
            end
        end
    endgenerate

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;

    // Counters saturate rather than wrap so a long run never reads back as small.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (stall && (stall_count_reg != '1))
                stall_count_reg <= stall_count_reg + 1'b1;
            if (flush && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit (DEPTH=2, LOAD_LAT=1); counter expectations follow HAZARD_STATS_EN.
module tb_pipe_hazard_unit;

    localparam int DEPTH = 2;
    localparam int FWD_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_wr_en;
    logic [4:0]       id_wr_addr;
    logic             id_is_load;
    logic             ex_redirect;
    logic             stall;
    logic             flush;
    logic [FWD_W-1:0] fwd_sel_a;
    logic [FWD_W-1:0] fwd_sel_b;
    logic [31:0]      stall_count;
    logic [31:0]      flush_count;

    int n_checks = 0;
    int n_bad    = 0;

    pipe_hazard_unit #(.DEPTH(DEPTH), .REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(stall), .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wen,
                         input logic [4:0] wa, input logic ld, input logic redir);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_wr_en    = wen;
        id_wr_addr  = wa;
        id_is_load  = ld;
        ex_redirect = redir;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 5'd3, 5'd3, 1, 1, 1, 5'd3, 0, 1);
        tick();
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_sel_a", 32'(fwd_sel_a), 0);
        check("rst_sel_b", 32'(fwd_sel_b), 0);
        tick();
        check("rst_scnt", stall_count, 0);
        reset = 1'b0;

        // addu $3 then read rs=$3 next cycle
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0);
        check("addu3_stall", 32'(stall), 0);
        tick();
        drive(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("fwd1_sel_a", 32'(fwd_sel_a), 1);
        check("fwd1_stall", 32'(stall), 0);
        tick();
        drive(1, 5'd0, 5'd3, 0, 1, 0, 5'd0, 0, 0);
        check("fwd2_sel_b", 32'(fwd_sel_b), 2);
        check("fwd2_sel_a", 32'(fwd_sel_a), 0);
        tick();
        drive(1, 5'd0, 5'd3, 0, 1, 0, 5'd0, 0, 0);
        check("aged_sel_b", 32'(fwd_sel_b), 0);
        tick();

        // load-use: lw $5 then read $5
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0);
        check("lw_stall", 32'(stall), 0);
        tick();
        drive(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("lu_stall", 32'(stall), 1);
        check("lu_sel_a", 32'(fwd_sel_a), 1);
        tick();
        drive(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("lu2_stall", 32'(stall), 0);
        check("lu2_sel_a", 32'(fwd_sel_a), 2);
        check("lu2_scnt", stall_count, STATS ? 1 : 0);
        tick();

        // invalid ID must not stall on a load match
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd6, 1, 0);
        tick();
        drive(0, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("inv_stall", 32'(stall), 0);
        tick();

        // two writers of $7: nearest wins; then $0 never forwards
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0);
        tick();
        drive(1, 5'd7, 5'd7, 1, 1, 1, 5'd0, 0, 0);
        check("near_sel_a", 32'(fwd_sel_a), 1);
        check("near_sel_b", 32'(fwd_sel_b), 1);
        tick();
        drive(1, 5'd0, 5'd7, 1, 1, 0, 5'd0, 0, 0);
        check("r0_sel_a", 32'(fwd_sel_a), 0);
        check("old7_sel_b", 32'(fwd_sel_b), 2);
        tick();

        // redirect beats load-use stall; the redirected ID writer becomes a bubble
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 5'd0, 1, 0, 1, 5'd9, 0, 1);
        check("rd_stall", 32'(stall), 0);
        check("rd_flush", 32'(flush), 1);
        check("rd_sel_a", 32'(fwd_sel_a), 1);
        tick();
        drive(1, 5'd9, 5'd5, 1, 1, 0, 5'd0, 0, 0);
        check("bub_sel_a", 32'(fwd_sel_a), 0);
        check("lw1_sel_b", 32'(fwd_sel_b), 2);
        check("lw1_stall", 32'(stall), 0);
        check("rd_fcnt", flush_count, STATS ? 1 : 0);
        check("rd_scnt", stall_count, STATS ? 1 : 0);
        tick();

        // reset asserted in the middle of a load-use stall
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("pre_rst_stall", 32'(stall), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_sel_a", 32'(fwd_sel_a), 0);
        tick();
        reset = 1'b0;
        drive(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        check("post_rst_sel_a", 32'(fwd_sel_a), 0);
        check("post_rst_stall", 32'(stall), 0);
        check("post_rst_scnt", stall_count, 0);
        check("post_rst_fcnt", flush_count, 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
